// File: rtl/pkt_echo_sender_pkg.sv
// Shared encodings and field offsets for the echo sender.
// Notification metadata layout and TCP tx-status field positions live here.
package top_k_pkg;

    localparam int NOTIF_W  = 88;
    localparam int SESS_LSB = 0;
    localparam int LEN_LSB  = 16;
    localparam int ERR_LSB  = 62;

    typedef enum logic [2:0] {
        STATE_IDLE        = 3'd0,
        STATE_META        = 3'd1,
        STATE_WAIT_STATUS = 3'd2,
        STATE_DATA        = 3'd3,
        STATE_DROP        = 3'd4
    } state_t;

    function automatic logic [31:0] tx_meta_word(input logic [15:0] sess, input logic [15:0] len);
        return {len, sess};
    endfunction

endpackage

// File: rtl/pkt_echo_sender.sv
// Echoes received messages to TCP tx: meta request, status wait, then forward or drop payload.
// Payload latency 1 cycle through a one-entry output register; input stalls only while that register is full and blocked.
module pkt_echo_sender
    import top_k_pkg::*;
#(
    parameter int STATUS_TIMEOUT = 1024,
    parameter int DATA_W         = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W+88:0]    s_axis_pkt_TDATA,
    input  logic                  s_axis_pkt_TVALID,
    output logic                  s_axis_pkt_TREADY,
    output logic [31:0]           m_axis_tx_meta_TDATA,
    output logic                  m_axis_tx_meta_TVALID,
    input  logic                  m_axis_tx_meta_TREADY,
    input  logic [63:0]           s_axis_tx_status_TDATA,
    input  logic                  s_axis_tx_status_TVALID,
    output logic                  s_axis_tx_status_TREADY,
    output logic [DATA_W-1:0]     m_axis_tx_data_TDATA,
    output logic [DATA_W/8-1:0]   m_axis_tx_data_TKEEP,
    output logic                  m_axis_tx_data_TLAST,
    output logic                  m_axis_tx_data_TVALID,
    input  logic                  m_axis_tx_data_TREADY,
    output logic [31:0]           pkt_sent_count,
    output logic [31:0]           pkt_drop_count
);

    localparam int CNT_W    = $clog2(STATUS_TIMEOUT + 1);
    localparam int META_LSB = DATA_W + 1;

    state_t              r_state;
    logic [31:0]         r_meta;
    logic                r_meta_vld;
    logic                r_status_rdy;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_out_dat;
    logic                r_out_last;
    logic                r_out_vld;
    logic [31:0]         r_sent;
    logic [31:0]         r_drop;

    logic [NOTIF_W-1:0]  w_notif;
    logic                w_pkt_last;
    logic                w_pkt_rdy;
    logic                w_pkt_acc;
    logic                w_status_acc;
    logic                w_status_err;
    logic                w_unused;

    assign w_notif      = s_axis_pkt_TDATA[META_LSB +: NOTIF_W];
    assign w_pkt_last   = s_axis_pkt_TDATA[DATA_W];
    assign w_status_acc = s_axis_tx_status_TVALID && r_status_rdy;
    assign w_status_err = s_axis_tx_status_TDATA[ERR_LSB +: 2] != 2'b00;
    assign w_unused     = ^{w_notif[NOTIF_W-1:32], s_axis_tx_status_TDATA[ERR_LSB-1:0]};

    // In DATA the input may advance whenever the output stage will be free at the next edge.
    assign w_pkt_rdy = (r_state == STATE_DROP) ||
                       ((r_state == STATE_DATA) && (!r_out_vld || m_axis_tx_data_TREADY));
    assign w_pkt_acc = s_axis_pkt_TVALID && w_pkt_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= STATE_IDLE;
            r_meta       <= '0;
            r_meta_vld   <= 1'b0;
            r_status_rdy <= 1'b0;
            r_cnt        <= '0;
            r_sent       <= '0;
            r_drop       <= '0;
        end else begin
            case (r_state)
                STATE_IDLE: begin
                    if (s_axis_pkt_TVALID) begin
                        r_meta     <= tx_meta_word(w_notif[SESS_LSB +: 16], w_notif[LEN_LSB +: 16]);
                        r_meta_vld <= 1'b1;
                        r_state    <= STATE_META;
                    end
                end
                STATE_META: begin
                    if (m_axis_tx_meta_TREADY) begin
                        r_meta_vld   <= 1'b0;
                        r_status_rdy <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= STATE_WAIT_STATUS;
                    end
                end
                STATE_WAIT_STATUS: begin
                    // A status landing in the final timeout cycle still takes priority.
                    if (w_status_acc) begin
                        r_status_rdy <= 1'b0;
                        r_state      <= w_status_err ? STATE_DROP : STATE_DATA;
                    end else if (r_cnt == CNT_W'(STATUS_TIMEOUT)) begin
                        r_status_rdy <= 1'b0;
                        r_state      <= STATE_DROP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STATE_DATA: begin
                    if (w_pkt_acc && w_pkt_last) begin
                        r_sent  <= r_sent + 32'd1;
                        r_state <= STATE_IDLE;
                    end
                end
                STATE_DROP: begin
                    if (w_pkt_acc && w_pkt_last) begin
                        r_drop  <= r_drop + 32'd1;
                        r_state <= STATE_IDLE;
                    end
                end
                default: r_state <= STATE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
            r_out_dat  <= '0;
        end else if ((r_state == STATE_DATA) && w_pkt_acc) begin
            r_out_vld  <= 1'b1;
            r_out_last <= w_pkt_last;
            r_out_dat  <= s_axis_pkt_TDATA[DATA_W-1:0];
        end else if (r_out_vld && m_axis_tx_data_TREADY) begin
            r_out_vld <= 1'b0;
        end
    end

    assign s_axis_pkt_TREADY       = w_pkt_rdy;
    assign m_axis_tx_meta_TDATA    = r_meta;
    assign m_axis_tx_meta_TVALID   = r_meta_vld;
    assign s_axis_tx_status_TREADY = r_status_rdy;
    assign m_axis_tx_data_TDATA    = r_out_dat;
    assign m_axis_tx_data_TKEEP    = '1;
    assign m_axis_tx_data_TLAST    = r_out_last;
    assign m_axis_tx_data_TVALID   = r_out_vld;
    assign pkt_sent_count          = r_sent;
    assign pkt_drop_count          = r_drop;

endmodule

// File: tb/tb_pkt_echo_sender.sv
// Directed bench for pkt_echo_sender: message table plus timeout, reset and burst sequences.
module tb_pkt_echo_sender;

    localparam int DATA_W  = 512;
    localparam int TIMEOUT = 1024;
    localparam logic [55:0] META_HI = 56'hA5A55A5AC3C33C;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [DATA_W+88:0]   in_dat = '0;
    logic                 in_vld = 1'b0;
    logic                 s_axis_pkt_TREADY;
    logic [31:0]          meta_dat;
    logic                 meta_vld;
    logic                 meta_rdy = 1'b0;
    logic [63:0]          st_dat = '0;
    logic                 st_vld = 1'b0;
    logic                 st_rdy;
    logic [DATA_W-1:0]    tx_dat;
    logic [DATA_W/8-1:0]  tx_keep;
    logic                 tx_last;
    logic                 tx_vld;
    logic                 tx_rdy = 1'b0;
    logic [31:0]          sent_cnt;
    logic [31:0]          drop_cnt;

    pkt_echo_sender #(.STATUS_TIMEOUT(TIMEOUT), .DATA_W(DATA_W)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .s_axis_pkt_TDATA        (in_dat),
        .s_axis_pkt_TVALID       (in_vld),
        .s_axis_pkt_TREADY       (s_axis_pkt_TREADY),
        .m_axis_tx_meta_TDATA    (meta_dat),
        .m_axis_tx_meta_TVALID   (meta_vld),
        .m_axis_tx_meta_TREADY   (meta_rdy),
        .s_axis_tx_status_TDATA  (st_dat),
        .s_axis_tx_status_TVALID (st_vld),
        .s_axis_tx_status_TREADY (st_rdy),
        .m_axis_tx_data_TDATA    (tx_dat),
        .m_axis_tx_data_TKEEP    (tx_keep),
        .m_axis_tx_data_TLAST    (tx_last),
        .m_axis_tx_data_TVALID   (tx_vld),
        .m_axis_tx_data_TREADY   (tx_rdy),
        .pkt_sent_count          (sent_cnt),
        .pkt_drop_count          (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tx_mode = 0;
    int seq = 1;
    int meta_issued = 0;
    int tlast_seen = 0;
    int acc_first = 0;
    int acc_last = 0;
    int exp_sent = 0;
    int exp_drop = 0;
    logic [DATA_W:0] exp_q[$];

    typedef struct {
        logic [15:0] sess;
        logic [15:0] len;
        logic [1:0]  err;
        int          smode;
        int          rmode;
        logic [31:0] exp_meta;
        bit          fwd;
    } vec_t;

    vec_t vecs[9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got no handshake expected one within bound", name);
    endtask

    function automatic logic [DATA_W+88:0] mk_beat(input logic [15:0] sess, input logic [15:0] len,
                                                   input logic last, input int s);
        logic [31:0] w;
        w = s;
        return {META_HI, len, sess, last, {16{w}}};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                0:       tx_rdy = 1'b1;
                1:       tx_rdy = ~tx_rdy;
                default: tx_rdy = 1'b0;
            endcase
        end
    end

    initial begin
        logic [DATA_W:0] e;
        forever begin
            @(negedge clk);
            if (!rst && tx_vld && tx_rdy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_tx_beat: got beat %0h expected none", tx_dat[31:0]);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_last", {63'd0, tx_last}, {63'd0, e[DATA_W]});
                    chk("tx_data_lo", tx_dat[63:0], e[63:0]);
                    chk("tx_data_full", {63'd0, tx_dat == e[DATA_W-1:0]}, 64'd1);
                    chk("tx_keep", tx_keep, 64'hFFFF_FFFF_FFFF_FFFF);
                end
            end
        end
    end

    task automatic drive_msg(input logic [15:0] sess, input logic [15:0] len, input bit fwd);
        int nb;
        bit ok;
        nb = int'(len) / 64;
        for (int b = 0; b < nb; b++) begin
            in_dat = mk_beat(sess, len, (b == nb - 1), seq);
            in_vld = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 3000; t++) begin
                @(negedge clk);
                if (s_axis_pkt_TREADY) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                fail_timeout("input_accept");
                break;
            end
            if (b == 0) acc_first = cyc;
            acc_last = cyc;
            if (fwd) exp_q.push_back(in_dat[DATA_W:0]);
            if (b == nb - 1) tlast_seen++;
            seq++;
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
    endtask

    task automatic respond(input logic [31:0] exp_meta, input logic [1:0] err, input int mode);
        bit ok;
        int n;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (meta_vld) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_timeout("meta_valid");
            return;
        end
        chk("meta_data", {32'd0, meta_dat}, {32'd0, exp_meta});
        chk("meta_order", meta_issued, tlast_seen);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("meta_hold", {31'd0, meta_vld, meta_dat}, {31'd0, 1'b1, exp_meta});
        meta_rdy = 1'b1;
        @(posedge clk);
        #1;
        meta_rdy = 1'b0;
        meta_issued++;
        case (mode)
            0: begin
                st_dat = {err, 30'h1234567, 16'hDEAD, 16'hBEEF};
                st_vld = 1'b1;
                ok = 1'b0;
                for (int t = 0; t < 200; t++) begin
                    @(negedge clk);
                    if (st_rdy) begin
                        ok = 1'b1;
                        break;
                    end
                end
                if (!ok) fail_timeout("status_ready");
                @(posedge clk);
                #1;
                st_vld = 1'b0;
            end
            1: begin
                n = 0;
                for (int t = 0; t < 2000; t++) begin
                    @(negedge clk);
                    if (!st_rdy) break;
                    n++;
                end
                chk("timeout_wait_cycles", n, TIMEOUT + 1);
            end
            default: begin
                repeat (TIMEOUT) @(negedge clk);
                @(posedge clk);
                #1;
                st_dat = {2'b00, 30'h0, 16'h0040, 16'h0022};
                st_vld = 1'b1;
                @(negedge clk);
                chk("status_rdy_at_limit", {63'd0, st_rdy}, 64'd1);
                @(posedge clk);
                #1;
                st_vld = 1'b0;
            end
        endcase
    endtask

    initial begin
        bit ok;
        int out_first;

        vecs[0] = '{16'h0005, 16'd128,  2'b00, 0, 0, 32'h0080_0005, 1'b1};
        vecs[1] = '{16'h000A, 16'd192,  2'b01, 0, 0, 32'h00C0_000A, 1'b0};
        vecs[2] = '{16'h000B, 16'd64,   2'b10, 0, 0, 32'h0040_000B, 1'b0};
        vecs[3] = '{16'h0011, 16'd64,   2'b00, 0, 1, 32'h0040_0011, 1'b1};
        vecs[4] = '{16'h0012, 16'd64,   2'b00, 0, 1, 32'h0040_0012, 1'b1};
        vecs[5] = '{16'h0021, 16'd128,  2'b00, 1, 0, 32'h0080_0021, 1'b0};
        vecs[6] = '{16'h0022, 16'd128,  2'b00, 2, 0, 32'h0080_0022, 1'b1};
        vecs[7] = '{16'hBEEF, 16'd256,  2'b11, 0, 1, 32'h0100_BEEF, 1'b0};
        vecs[8] = '{16'h1234, 16'd320,  2'b00, 0, 1, 32'h0140_1234, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_meta_vld", {63'd0, meta_vld}, 64'd0);
        chk("rst_status_rdy", {63'd0, st_rdy}, 64'd0);
        chk("rst_pkt_rdy", {63'd0, s_axis_pkt_TREADY}, 64'd0);
        chk("rst_tx_vld", {63'd0, tx_vld}, 64'd0);
        chk("rst_counts", {sent_cnt, drop_cnt}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            tx_mode = vecs[i].rmode;
            fork
                drive_msg(vecs[i].sess, vecs[i].len, vecs[i].fwd);
                respond(vecs[i].exp_meta, vecs[i].err, vecs[i].smode);
            join
            if (vecs[i].fwd) exp_sent++;
            else exp_drop++;
            chk("sent_count", {32'd0, sent_cnt}, 64'(exp_sent));
            chk("drop_count", {32'd0, drop_cnt}, 64'(exp_drop));
        end

        tx_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("drain_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a message with the output register held full.
        tx_mode = 2;
        @(posedge clk);
        #1;
        in_dat = mk_beat(16'h0077, 16'd256, 1'b0, seq);
        in_vld = 1'b1;
        respond(32'h0100_0077, 2'b00, 0);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (s_axis_pkt_TREADY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_timeout("reset_seq_accept");
        seq++;
        @(posedge clk);
        #1;
        in_dat = mk_beat(16'h0077, 16'd256, 1'b0, seq);
        seq++;
        repeat (2) @(negedge clk);
        chk("stall_tx_vld", {63'd0, tx_vld}, 64'd1);
        chk("stall_pkt_rdy", {63'd0, s_axis_pkt_TREADY}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tx_vld", {63'd0, tx_vld}, 64'd0);
        chk("arst_pkt_rdy", {63'd0, s_axis_pkt_TREADY}, 64'd0);
        chk("arst_meta_st", {62'd0, meta_vld, st_rdy}, 64'd0);
        chk("arst_counts", {sent_cnt, drop_cnt}, 64'd0);
        in_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tlast_seen = meta_issued;
        exp_sent = 0;
        exp_drop = 0;
        tx_mode = 0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {61'd0, meta_vld, st_rdy, tx_vld}, 64'd0);
        @(posedge clk);
        #1;

        // 24-beat burst: 1 beat/cycle with one cycle of latency.
        out_first = 0;
        fork
            drive_msg(16'h0033, 16'd1536, 1'b1);
            respond(32'h0600_0033, 2'b00, 0);
            begin
                ok = 1'b0;
                for (int t = 0; t < 500; t++) begin
                    @(negedge clk);
                    if (tx_vld) begin
                        ok = 1'b1;
                        out_first = cyc;
                        break;
                    end
                end
                if (!ok) fail_timeout("burst_first_out");
            end
        join
        chk("burst_first_latency", out_first - acc_first, 1);
        chk("burst_span", acc_last - acc_first, 23);
        chk("burst_sent", {32'd0, sent_cnt}, 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_drop", {32'd0, drop_cnt}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pkt_echo_sender.md
Name: pkt_echo_sender

Overview:
- Sits directly downstream of the packet receiver stage that emits {88-bit notification metadata, tlast, 512-bit data} beats.
- For each received message it issues a TCP tx-metadata request (session, length) and waits for the tx-status response.
- On success it forwards the payload beats to the TCP tx-data stream. On error or timeout it drains and discards them.
- Keeps sent/dropped message counters for the kernel control registers.

Parameters:
- STATUS_TIMEOUT, 1024: cycles to wait in WAIT_STATUS before the message is dropped; counter width is clog2(STATUS_TIMEOUT+1).
- DATA_W, 512: payload beat width; TKEEP width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_axis_pkt_TDATA  in  DATA_W+89  {meta[87:0], tlast, data}; meta[15:0]=sessionID, meta[31:16]=length in bytes
- s_axis_pkt_TVALID  in  1  beat valid
- s_axis_pkt_TREADY  out  1  beat accepted
- m_axis_tx_meta_TDATA  out  32  {length[31:16], sessionID[15:0]}
- m_axis_tx_meta_TVALID  out  1
- m_axis_tx_meta_TREADY  in  1
- s_axis_tx_status_TDATA  in  64  [15:0] session, [31:16] length, [61:32] space, [63:62] error
- s_axis_tx_status_TVALID  in  1
- s_axis_tx_status_TREADY  out  1
- m_axis_tx_data_TDATA  out  DATA_W  payload
- m_axis_tx_data_TKEEP  out  DATA_W/8  always all-ones; lengths are multiples of 64 B
- m_axis_tx_data_TLAST  out  1  copy of input tlast
- m_axis_tx_data_TVALID  out  1
- m_axis_tx_data_TREADY  in  1
- pkt_sent_count  out  32  messages fully forwarded
- pkt_drop_count  out  32  messages discarded

Behaviour:
- Reset (async assert, all state): state=IDLE; all TVALID/TREADY outputs 0; counters 0; output data register empty.
- Handshake: transfer on VALID&READY. A VALID is held with stable DATA until accepted.
- States:
  - IDLE: when s_axis_pkt_TVALID=1, latch meta[31:0] of the head beat without consuming it. Next cycle goes to META.
  - META: m_axis_tx_meta_TVALID=1 with the latched {length, session}. On accept go to WAIT_STATUS and clear the timeout counter.
  - WAIT_STATUS: s_axis_tx_status_TREADY=1 and the timeout counter increments each cycle.
    - Status accepted with error==0 goes to DATA.
    - Status accepted with error!=0 goes to DROP.
    - If the counter reaches STATUS_TIMEOUT with no status, go to DROP. A status arriving in that same cycle wins.
  - DATA: s_axis_pkt_TREADY = output register empty OR m_axis_tx_data_TREADY. Each accepted beat loads the output register on the next edge (latency 1 cycle; full throughput of 1 beat/cycle). When the tlast beat is accepted, go to IDLE and increment pkt_sent_count.
  - DROP: s_axis_pkt_TREADY=1 and beats are discarded. When the tlast beat is accepted, go to IDLE and increment pkt_drop_count.
- Output register: a one-entry pipeline stage.
  - Holds its beat while m_axis_tx_data_TREADY=0.
  - Drain and load in the same cycle is allowed.
  - The IDLE→META transition for the next message may overlap draining of the previous message's last beat.
- Ordering: meta for message N+1 is not issued until message N's tlast beat has been accepted on the input.
- Counters wrap modulo 2^32.
- Status session/length fields are not compared; they are ignored.
- Zero-length metadata never arrives; it is filtered upstream.
- Reset mid-message:
  - All state clears immediately.
  - Any beat in the output register is lost and TVALID drops asynchronously.
  - Upstream residual beats are then treated as a new message head.

Decomposition:
- Shared package top_k_pkg holds:
  - STATE_IDLE/META/WAIT_STATUS/DATA/DROP encodings
  - Field offsets SESS_LSB=0, LEN_LSB=16, ERR_LSB=62
  - NOTIF_W=88
- No sub-module; the output stage is an inline register.

Test Plan:
1. Single 128 B message, session 0x0005, status error=0, all readies high → meta 0x00800005 issued; 2 data beats forwarded, second with TLAST=1; TKEEP=64'hFFFF_FFFF_FFFF_FFFF; pkt_sent_count=1.
2. Status error=2'b01 for a 192 B message → 3 input beats consumed, no tx_data TVALID; pkt_drop_count=1.
3. No status for 1024 cycles → DROP entered at cycle 1024 after meta accept, payload drained; pkt_drop_count=1. A status given at exactly cycle 1024 → DATA instead.
4. Back-to-back 64 B messages with m_axis_tx_data_TREADY toggling 1/0 → data order preserved, no beat duplicated or lost, second meta issued only after first tlast input accept.
5. Assert rst while in DATA mid-message → all outputs 0 asynchronously, counters 0, state IDLE after release.
6. 1536 B message with continuous readies → 24 beats at 1 beat/cycle, first output beat one cycle after first input accept.
